// File: rtl/demultiplexer_1to2_stream.sv
// ---------------------------------------------------------------------------
// demultiplexer_1to2_stream
//   Registered 1-to-2 stream demultiplexer. One producer stream is steered to
//   one of two consumer streams. Each consumer has a private 2-entry buffer,
//   so a stalled consumer never blocks or corrupts the other one.
//
// Ports
//   clk, reset           clock / asynchronous active-low reset
//   In_Valid/In_Data     producer word
//   Selector             1 -> port 0, 0 -> port 1
//   In_Ready             selected buffer has space (never sees Out*_Ready)
//   Out0_*/Out1_*        consumer streams, registered head word
//   Count0/Count1        words delivered per port, wrapping
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux_stream_buffer
//   Two-entry FIFO for one output port. The head word lives in its own
//   register so the output data never passes through a read mux.
//
// Ports
//   clk, reset     clock / asynchronous active-low reset
//   push, push_data  write one word (caller guarantees !full)
//   pop_ready      consumer ready; a pop happens only while valid
//   valid, data    head word
//   full           two entries held
//   count          delivered-word counter, wraps
// ---------------------------------------------------------------------------
module demux_stream_buffer #(
   parameter int NBits     = 16,
   parameter int CountBits = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [NBits-1:0]     push_data,
   input  logic                 pop_ready,
   output logic                 valid,
   output logic [NBits-1:0]     data,
   output logic                 full,
   output logic [CountBits-1:0] count
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   occ_t             occ;
   logic [NBits-1:0] head;
   logic [NBits-1:0] tail;
   logic             pop;

   assign valid = (occ != OCC_EMPTY);
   assign full  = (occ == OCC_TWO);
   assign data  = head;
   // Ready while empty is ignored.
   assign pop   = valid & pop_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ   <= OCC_EMPTY;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (push) begin
                  head <= push_data;
                  occ  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  // Head leaves, the incoming word replaces it directly.
                  head <= push_data;
               end else if (push) begin
                  tail <= push_data;
                  occ  <= OCC_TWO;
               end else if (pop) begin
                  // head keeps its stale value so data holds while !valid
                  occ <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // No push can arrive here: the producer sees !ready.
               if (pop) begin
                  head <= tail;
                  occ  <= OCC_ONE;
               end
            end
            default: occ <= OCC_EMPTY;
         endcase

         if (pop) count <= count + CountBits'(1);
      end
   end

endmodule

module demultiplexer_1to2_stream #(
   parameter int NBits     = 16,
   parameter int CountBits = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 In_Valid,
   input  logic [NBits-1:0]     In_Data,
   input  logic                 Selector,
   output logic                 In_Ready,
   output logic                 Out0_Valid,
   output logic [NBits-1:0]     Out0_Data,
   input  logic                 Out0_Ready,
   output logic                 Out1_Valid,
   output logic [NBits-1:0]     Out1_Data,
   input  logic                 Out1_Ready,
   output logic [CountBits-1:0] Count0,
   output logic [CountBits-1:0] Count1
);

   localparam int NumPorts = 2;

   logic [NumPorts-1:0]                route;
   logic [NumPorts-1:0]                push;
   logic [NumPorts-1:0]                pop_ready;
   logic [NumPorts-1:0]                valid;
   logic [NumPorts-1:0]                full;
   logic [NumPorts-1:0][NBits-1:0]     data;
   logic [NumPorts-1:0][CountBits-1:0] count;
   logic                               accept;

   // One-hot destination: Selector==1 picks port 0, matching the 2-to-1 muxes.
   assign route     = {~Selector, Selector};
   // Only the selected buffer's occupancy matters; consumer ready is not
   // consulted, so a full buffer frees space one cycle after its pop.
   assign In_Ready  = reset & |(route & ~full);
   assign accept    = In_Valid & In_Ready;
   assign push      = route & {NumPorts{accept}};
   assign pop_ready = {Out1_Ready, Out0_Ready};

   for (genvar k = 0; k < NumPorts; k++) begin : g_port
      demux_stream_buffer #(
         .NBits     (NBits),
         .CountBits (CountBits)
      ) u_buf (
         .clk       (clk),
         .reset     (reset),
         .push      (push[k]),
         .push_data (In_Data),
         .pop_ready (pop_ready[k]),
         .valid     (valid[k]),
         .data      (data[k]),
         .full      (full[k]),
         .count     (count[k])
      );
   end

   assign Out0_Valid = valid[0];
   assign Out0_Data  = data[0];
   assign Count0     = count[0];
   assign Out1_Valid = valid[1];
   assign Out1_Data  = data[1];
   assign Count1     = count[1];

endmodule

// File: tb/tb_demultiplexer_1to2_stream.sv
// ---------------------------------------------------------------------------
// tb_demultiplexer_1to2_stream
//   Directed stimulus with a per-port scoreboard: accepted words are queued
//   at the handshake, and checked in order when the port delivers them.
// ---------------------------------------------------------------------------
module tb_demultiplexer_1to2_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        In_Valid;
   logic [15:0] In_Data;
   logic        Selector;
   logic        In_Ready;
   logic        Out0_Valid;
   logic [15:0] Out0_Data;
   logic        Out0_Ready;
   logic        Out1_Valid;
   logic [15:0] Out1_Data;
   logic        Out1_Ready;
   logic [7:0]  Count0;
   logic [7:0]  Count1;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   logic [7:0]  exp_cnt0 = 8'd0;
   logic [7:0]  exp_cnt1 = 8'd0;

   demultiplexer_1to2_stream #(.NBits(16), .CountBits(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .In_Valid   (In_Valid),
      .In_Data    (In_Data),
      .Selector   (Selector),
      .In_Ready   (In_Ready),
      .Out0_Valid (Out0_Valid),
      .Out0_Data  (Out0_Data),
      .Out0_Ready (Out0_Ready),
      .Out1_Valid (Out1_Valid),
      .Out1_Data  (Out1_Data),
      .Out1_Ready (Out1_Ready),
      .Count0     (Count0),
      .Count1     (Count1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are sampled mid-cycle; inputs are stable until the next edge.
   always @(negedge clk) begin
      if (reset) begin
         check("out0_valid", Out0_Valid, q0.size() != 0);
         check("out1_valid", Out1_Valid, q1.size() != 0);
         check("count0", Count0, exp_cnt0);
         check("count1", Count1, exp_cnt1);
         if (Out0_Valid && Out0_Ready && q0.size() != 0) begin
            check("out0_data", Out0_Data, q0.pop_front());
            exp_cnt0 = exp_cnt0 + 8'd1;
         end
         if (Out1_Valid && Out1_Ready && q1.size() != 0) begin
            check("out1_data", Out1_Data, q1.pop_front());
            exp_cnt1 = exp_cnt1 + 8'd1;
         end
         if (In_Valid && In_Ready) begin
            if (Selector) q0.push_back(In_Data);
            else          q1.push_back(In_Data);
         end
      end
   end

   task automatic send(input logic sel, input logic [15:0] d);
      int n = 0;
      In_Valid = 1'b1;
      Selector = sel;
      In_Data  = d;
      #1;
      while (!In_Ready && n < 40) begin
         step();
         n++;
      end
      check("send_ready", In_Ready, 1);
      step();
      In_Valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_left", q0.size() + q1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      In_Valid   = 1'b0;
      In_Data    = 16'h0;
      Selector   = 1'b1;
      Out0_Ready = 1'b0;
      Out1_Ready = 1'b0;
      #2;
      check("rst_in_ready", In_Ready, 0);
      check("rst_out0_valid", Out0_Valid, 0);
      check("rst_out1_valid", Out1_Valid, 0);
      check("rst_out0_data", Out0_Data, 16'h0);
      check("rst_out1_data", Out1_Data, 16'h0);
      check("rst_count0", Count0, 8'h0);
      step();
      step();
      reset = 1'b1;
      step();

      // Single route with one-cycle latency.
      Out0_Ready = 1'b1;
      Selector   = 1'b1;
      In_Data    = 16'hA5A5;
      In_Valid   = 1'b1;
      #1;
      check("single_in_ready", In_Ready, 1);
      step();
      In_Valid = 1'b0;
      check("single_out0_valid", Out0_Valid, 1);
      check("single_out0_data", Out0_Data, 16'hA5A5);
      check("single_count0_pre", Count0, 8'd0);
      check("single_out1_idle", Out1_Valid, 0);
      step();
      check("single_count0", Count0, 8'd1);
      check("single_out0_empty", Out0_Valid, 0);
      check("single_data_hold", Out0_Data, 16'hA5A5);

      // Back-pressure on port 1.
      Out1_Ready = 1'b0;
      send(1'b0, 16'h0001);
      send(1'b0, 16'h0002);
      In_Valid = 1'b1;
      Selector = 1'b0;
      In_Data  = 16'h0003;
      #1;
      check("bp_full_ready", In_Ready, 0);
      step();
      check("bp_full_ready2", In_Ready, 0);
      Out1_Ready = 1'b1;
      #1;
      check("bp_no_comb_path", In_Ready, 0);
      step();
      check("bp_space_ready", In_Ready, 1);
      step();
      In_Valid = 1'b0;
      drain();
      step();
      check("bp_count1", Count1, 8'd3);

      // Port 1 full and stalled, port 0 still flows.
      Out1_Ready = 1'b0;
      send(1'b0, 16'hBEE1);
      send(1'b0, 16'hBEE2);
      Out0_Ready = 1'b1;
      Selector   = 1'b1;
      In_Data    = 16'h1234;
      In_Valid   = 1'b1;
      #1;
      check("ind_in_ready", In_Ready, 1);
      step();
      In_Valid = 1'b0;
      check("ind_out0_data", Out0_Data, 16'h1234);
      step();
      step();
      check("ind_out1_valid", Out1_Valid, 1);
      check("ind_out1_data", Out1_Data, 16'hBEE1);
      check("ind_count1", Count1, 8'd3);
      Out1_Ready = 1'b1;
      drain();

      // Steady push/pop at occupancy 1.
      Out0_Ready = 1'b1;
      Selector   = 1'b1;
      In_Valid   = 1'b1;
      for (int i = 16'h10; i <= 16'h1F; i++) begin
         In_Data = 16'(i);
         #1;
         check("stream_in_ready", In_Ready, 1);
         step();
      end
      In_Valid = 1'b0;
      drain();
      step();
      check("stream_count0", Count0, 8'd18);

      // Asynchronous reset with two words queued on port 0.
      Out0_Ready = 1'b0;
      send(1'b1, 16'hC001);
      send(1'b1, 16'hC002);
      reset = 1'b0;
      #1;
      check("mid_rst_out0_valid", Out0_Valid, 0);
      check("mid_rst_count0", Count0, 8'd0);
      check("mid_rst_out0_data", Out0_Data, 16'h0);
      check("mid_rst_in_ready", In_Ready, 0);
      q0.delete();
      q1.delete();
      exp_cnt0 = 8'd0;
      exp_cnt1 = 8'd0;
      step();
      reset = 1'b1;
      Selector = 1'b1;
      #1;
      check("post_rst_ready_sel1", In_Ready, 1);
      Selector = 1'b0;
      #1;
      check("post_rst_ready_sel0", In_Ready, 1);
      step();

      // Counter wrap: 257 deliveries on port 0.
      Out0_Ready = 1'b1;
      Selector   = 1'b1;
      In_Valid   = 1'b1;
      for (int i = 0; i < 257; i++) begin
         In_Data = 16'(i + 16'h0100);
         step();
      end
      In_Valid = 1'b0;
      drain();
      step();
      check("wrap_count0", Count0, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demultiplexer_1to2_stream.md
Name: demultiplexer_1to2_stream

Overview:
- Registered 1-to-2 stream demultiplexer. It is the fan-out counterpart of the datapath 2-to-1 multiplexers: one producer stream is routed to one of two consumer streams.
- Each output has its own 2-entry buffer, so back-pressure on one destination never corrupts or stalls data already queued for the other.
- Per-output transfer counters are provided for debug and test.
- Sits between the operand source and the two multiplier/accumulator consumer paths.

Parameters:
- NBits, 16, data word width.
- CountBits, 8, width of each per-output transfer counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- In_Valid  input  1  producer presents a word.
- In_Data  input  NBits  producer word.
- Selector  input  1  destination; 1 routes to port 0, 0 routes to port 1 (same polarity as the codebase 2-to-1 multiplexers).
- In_Ready  output  1  block accepts the word this cycle.
- Out0_Valid  output  1  port 0 head word valid.
- Out0_Data  output  NBits  port 0 head word.
- Out0_Ready  input  1  port 0 consumer takes the head word.
- Out1_Valid  output  1  port 1 head word valid.
- Out1_Data  output  NBits  port 1 head word.
- Out1_Ready  input  1  port 1 consumer takes the head word.
- Count0  output  CountBits  words delivered on port 0.
- Count1  output  CountBits  words delivered on port 1.

Behaviour:
- Reset (reset==0, asynchronous):
  - Both buffers are emptied.
  - Out0_Valid=0, Out1_Valid=0, Out0_Data=0, Out1_Data=0, Count0=0, Count1=0.
  - In_Ready=0 while reset is asserted.
  - Reset mid-operation discards all queued words; no partial transfer survives.
- Accept: a word is accepted on a rising edge when In_Valid && In_Ready.
- In_Ready: combinational from Selector and the occupancy of the selected buffer only. It is 1 iff that buffer holds fewer than 2 entries. There is no combinational path from Out*_Ready to In_Ready.
- Routing: the accepted word is written to buffer 0 if Selector==1, otherwise to buffer 1. The other buffer is untouched.
- Buffer: 2-entry FIFO per port with occupancy 0/1/2 as its states.
  - Out*_Valid = occupancy != 0.
  - Out*_Data = oldest entry, driven from a register.
  - Out*_Data holds its value while Out*_Valid==0.
- Deliver: a word leaves port k on a rising edge when Outk_Valid && Outk_Ready. Countk then increments by 1 and wraps modulo 2^CountBits (0xFF -> 0x00 at the default width).
- Latency: a word accepted at edge N is visible at Out*_Valid/Data after edge N (one cycle). There is no combinational bypass.
- Occupancy 1 with simultaneous push and pop on the same port: occupancy stays 1. The new word becomes the head after the edge.
- Occupancy 2: In_Ready=0 for that port even if Outk_Ready=1 in the same cycle. Space appears the following cycle.
- Pop on an empty buffer: no effect.
- Ordering: FIFO order is preserved per port. No ordering is guaranteed between ports.
- Out*_Ready asserted while Valid==0: ignored.
- In_Valid==0: Selector and In_Data are don't-care; no state change.
- Producer side: the producer must hold In_Data and Selector stable while In_Valid && !In_Ready. The block does not check this.

Test Plan:
- Reset then idle: assert reset=0 mid-stream with 2 words queued on port 0 -> Out0_Valid=0, Count0=0 immediately (asynchronous); after release, In_Ready=1 for both Selector values.
- Single route: NBits=16, Selector=1, In_Data=0xA5A5, Out0_Ready=1 -> Out0_Valid=1 with 0xA5A5 one cycle later; Count0=1 after the next edge; port 1 stays idle.
- Back-pressure: Out1_Ready=0, send 0x0001, 0x0002, 0x0003 with Selector=0 -> In_Ready drops after 2 accepts; raising Out1_Ready yields 0x0001, then 0x0002, then 0x0003 (accepted once space appears); Count1=3.
- Independence: port 1 full and stalled, Selector=1 with 0x1234 -> In_Ready=1 and 0x1234 is delivered on port 0 while port 1 contents are unchanged.
- Simultaneous push/pop at occupancy 1: steady stream of 0x0010..0x001F on port 0 with Out0_Ready=1 -> In_Ready stays 1 and one word is delivered per cycle in order.
- Counter wrap: CountBits=8, deliver 257 words on port 0 -> Count0=0x01.
